// File: rtl/key_expansion_pkg.sv
// Shared types, constants and helpers for the AES-128 key schedule.
package key_expansion_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  // Round constants, indexed 1..10 (entry 1 is the constant used to build round 1).
  localparam logic [10:1][7:0] RCON = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
  };

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Cyclic left rotate of a word by one byte: {a,b,c,d} -> {b,c,d,a}.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/key_expansion_subword.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word (purely combinational).
module key_expansion_subword (
  input  logic [31:0] word,
  output logic [31:0] sub
);

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign sub = {SBOX[word[31:24]], SBOX[word[23:16]], SBOX[word[15:8]], SBOX[word[7:0]]};

endmodule

// File: rtl/key_expansion.sv
// Sequential AES-128 key schedule: one round key per accepted valid/ready handshake.
// Build option KEY_EXPANSION_RCON_LUT_EN: take Rcon from a constant table instead of
// a running xtime register. Both builds produce the same round-key sequence.
//
// state | meaning
// IDLE  | waiting for start; key_in loaded when start=1
// EMIT  | round_key valid; advances on each rk_ready handshake
// DONE  | one-cycle done pulse after round 10 accepted
module key_expansion
  import key_expansion_pkg::*;
#(
  parameter int BYTE   = 8,
  parameter int DWORD  = 32,
  parameter int LENGTH = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LENGTH-1:0] key_in,
  output logic [LENGTH-1:0] round_key,
  output logic [3:0]        rk_index,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic              busy,
  output logic              done
);

  state_t            state_q, state_d;
  logic [LENGTH-1:0] key_q;
  logic [3:0]        idx_q;
  logic              load, advance;
  logic [7:0]        rcon;
  logic [DWORD-1:0]  w0, w1, w2, w3, rot_w, sub_w, t, n0, n1, n2, n3;

  assign load    = (state_q == IDLE) && start;
  assign advance = (state_q == EMIT) && rk_ready && (idx_q != LAST_ROUND);

  assign {w0, w1, w2, w3} = key_q;
  assign rot_w = rot_word(w3);

  key_expansion_subword u_subword (
    .word (rot_w),
    .sub  (sub_w)
  );

`ifdef KEY_EXPANSION_RCON_LUT_EN
  // Table lookup for the constant of the round being built; guarded so index 11 is never read.
  always_comb begin
    rcon = 8'h00;
    if (idx_q < LAST_ROUND) rcon = RCON[idx_q + 4'd1];
  end
`else
  logic [7:0] rcon_q;

  // Running round constant: 01 on load, doubled in GF(2^8) on every advancing handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rcon_q <= 8'h01;
    else if (load)    rcon_q <= 8'h01;
    else if (advance) rcon_q <= xtime(rcon_q);
  end

  assign rcon = rcon_q;
`endif

  assign t  = sub_w ^ {rcon, {(DWORD-BYTE){1'b0}}};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = EMIT;
      EMIT:    if (rk_ready && (idx_q == LAST_ROUND)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Key register and round index: load on start, step on each non-final handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q <= '0;
      idx_q <= '0;
    end else if (load) begin
      key_q <= key_in;
      idx_q <= '0;
    end else if (advance) begin
      key_q <= {n0, n1, n2, n3};
      idx_q <= idx_q + 4'd1;
    end
  end

  assign round_key = key_q;
  assign rk_index  = idx_q;
  assign rk_valid  = (state_q == EMIT);
  assign busy      = (state_q == EMIT);
  assign done      = (state_q == DONE);

endmodule
